// File: rtl/uart_tx_if.sv
// Byte push handshake into the UART transmitter FIFO.
// The producer drives data/valid; the transmitter answers with a registered ready.
interface uart_tx_if;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady;

    modport master (output iData, output iValid, input oReady);
    modport slave  (input iData, input iValid, output oReady);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// Frames are sent back to back while the FIFO holds data.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        iClock,
    input  logic        iReset,
    uart_tx_if.slave    bus,
    output logic        oTx,
    output logic        oBusy,
    output logic [4:0]  oFifoCount,
    output logic        oOverflow
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  DEPTH_C   = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             stateQ, stateD;
    logic [15:0]        baudQ, baudD;
    logic [2:0]         bitIdxQ, bitIdxD;
    logic [7:0]         shiftQ, shiftD;
    logic               txQ, txD;
    logic [PTR_W-1:0]   wrPtrQ, wrPtrD;
    logic [PTR_W-1:0]   rdPtrQ, rdPtrD;
    logic [4:0]         countQ, countD;
    logic               readyQ, readyD;
    logic               overflowQ, overflowD;
    logic [7:0]         fifoMem [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               lastTick;

    assign push     = bus.iValid & readyQ;
    assign lastTick = (baudQ == LAST_TICK);

    // Storage is never reset; an empty count makes stale entries unreachable.
    always_ff @(posedge iClock) begin
        if (push) begin
            fifoMem[wrPtrQ] <= bus.iData;
        end
    end

    always_comb begin
        stateD  = stateQ;
        baudD   = baudQ;
        bitIdxD = bitIdxQ;
        shiftD  = shiftQ;
        pop     = 1'b0;

        case (stateQ)
            IDLE: begin
                if (countQ != 5'd0) begin
                    pop     = 1'b1;
                    shiftD  = fifoMem[rdPtrQ];
                    baudD   = 16'd0;
                    bitIdxD = 3'd0;
                    stateD  = START;
                end
            end
            START: begin
                if (lastTick) begin
                    baudD  = 16'd0;
                    stateD = DATA;
                end else begin
                    baudD = baudQ + 16'd1;
                end
            end
            DATA: begin
                if (lastTick) begin
                    baudD  = 16'd0;
                    shiftD = {1'b0, shiftQ[7:1]};
                    if (bitIdxQ == 3'd7) begin
                        stateD = STOP;
                    end else begin
                        bitIdxD = bitIdxQ + 3'd1;
                    end
                end else begin
                    baudD = baudQ + 16'd1;
                end
            end
            STOP: begin
                if (lastTick) begin
                    baudD = 16'd0;
                    // Chain straight into the next start bit so queued bytes leave no gap.
                    if (countQ != 5'd0) begin
                        pop     = 1'b1;
                        shiftD  = fifoMem[rdPtrQ];
                        bitIdxD = 3'd0;
                        stateD  = START;
                    end else begin
                        stateD = IDLE;
                    end
                end else begin
                    baudD = baudQ + 16'd1;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        // The line level is derived from the next state so oTx can be a plain flop.
        case (stateD)
            START:   txD = 1'b0;
            DATA:    txD = shiftD[0];
            default: txD = 1'b1;
        endcase
    end

    always_comb begin
        wrPtrD    = wrPtrQ + PTR_W'(push);
        rdPtrD    = rdPtrQ + PTR_W'(pop);
        countD    = countQ + 5'(push) - 5'(pop);
        readyD    = (countD < DEPTH_C);
        overflowD = bus.iValid & ~readyQ;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            stateQ    <= IDLE;
            baudQ     <= 16'd0;
            bitIdxQ   <= 3'd0;
            shiftQ    <= 8'd0;
            txQ       <= 1'b1;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            countQ    <= 5'd0;
            readyQ    <= 1'b1;
            overflowQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            baudQ     <= baudD;
            bitIdxQ   <= bitIdxD;
            shiftQ    <= shiftD;
            txQ       <= txD;
            wrPtrQ    <= wrPtrD;
            rdPtrQ    <= rdPtrD;
            countQ    <= countD;
            readyQ    <= readyD;
            overflowQ <= overflowD;
        end
    end

    assign bus.oReady = readyQ;
    assign oTx        = txQ;
    assign oBusy      = (stateQ != IDLE) || (countQ != 5'd0);
    assign oFifoCount = countQ;
    assign oOverflow  = overflowQ;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx with a line decoder and a
// cycle-level FIFO/frame-timing reference model.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       oTx;
    logic       oBusy;
    logic [4:0] oFifoCount;
    logic       oOverflow;

    int checks   = 0;
    int failures = 0;

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .iClock     (clk),
        .iReset     (rst),
        .bus        (bus),
        .oTx        (oTx),
        .oBusy      (oBusy),
        .oFifoCount (oFifoCount),
        .oOverflow  (oOverflow)
    );

    always #5 clk = ~clk;

    // Line decoder: finds a start bit, samples mid-bit, checks start/stop levels.
    logic [7:0] rxQ [$];
    int         framingErr = 0;
    bit         monActive  = 0;
    int         monCnt     = 0;
    logic [7:0] monByte    = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            monActive = 0;
        end else if (!monActive) begin
            if (oTx === 1'b0) begin
                monActive = 1;
                monCnt    = 0;
            end
        end else begin
            monCnt++;
            if (monCnt == 2 && oTx !== 1'b0) framingErr++;
            if (monCnt >= 6 && monCnt <= 34 && (monCnt % 4) == 2) monByte[(monCnt - 6) / 4] = oTx;
            if (monCnt == 38) begin
                if (oTx !== 1'b1) framingErr++;
                rxQ.push_back(monByte);
            end
            if (monCnt == 39) monActive = 0;
        end
    end

    function automatic logic frameBit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j - 1];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.iValid = 1'b0;
        bus.iData  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (oTx !== 1'b1)        begin failures++; $display("[TB] FAIL reset_tx got=%b exp=1", oTx); end
        checks++; if (bus.oReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.oReady); end
        checks++; if (oBusy !== 1'b0)      begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", oBusy); end
        checks++; if (oFifoCount !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", oFifoCount); end
        checks++; if (oOverflow !== 1'b0)  begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", oOverflow); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] b;
        for (int n = 0; n < 4; n++) begin
            b = (n == 0) ? 8'h55 : 8'($urandom_range(0, 255));
            framingErr = 0;
            rxQ.delete();
            @(negedge clk);
            bus.iData  = b;
            bus.iValid = 1'b1;
            @(posedge clk);
            #1 bus.iValid = 1'b0;
            @(negedge clk);
            checks++; if (oTx !== 1'b1)        begin failures++; $display("[TB] FAIL single_pre_tx byte=%h got=%b exp=1", b, oTx); end
            checks++; if (oFifoCount !== 5'd1) begin failures++; $display("[TB] FAIL single_pre_count got=%0d exp=1", oFifoCount); end
            checks++; if (oBusy !== 1'b1)      begin failures++; $display("[TB] FAIL single_pre_busy got=%b exp=1", oBusy); end
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                checks++;
                if (oTx !== frameBit(b, c / CPB)) begin
                    failures++;
                    $display("[TB] FAIL single_bit byte=%h cycle=%0d got=%b exp=%b", b, c, oTx, frameBit(b, c / CPB));
                end
                if (c == 0) begin
                    checks++; if (oFifoCount !== 5'd0) begin failures++; $display("[TB] FAIL single_popcount got=%0d exp=0", oFifoCount); end
                end
            end
            @(negedge clk);
            checks++; if (oBusy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_end got=%b exp=0", oBusy); end
            checks++; if (oTx !== 1'b1)   begin failures++; $display("[TB] FAIL single_idle_tx got=%b exp=1", oTx); end
            checks++;
            if (rxQ.size() != 1 || rxQ[0] !== b) begin
                failures++;
                $display("[TB] FAIL single_decode n=%0d got=%h exp=%h", rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 8'hxx, b);
            end
            checks++; if (framingErr != 0) begin failures++; $display("[TB] FAIL single_framing got=%0d exp=0", framingErr); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bb [2];
        bb[0] = 8'hA3;
        bb[1] = 8'h0F;
        framingErr = 0;
        rxQ.delete();
        @(negedge clk);
        bus.iData  = bb[0];
        bus.iValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.iData = bb[1];
        @(posedge clk);
        #1 bus.iValid = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (oTx !== frameBit(bb[c / FRAME], (c % FRAME) / CPB)) begin
                failures++;
                $display("[TB] FAIL b2b_bit cycle=%0d got=%b exp=%b", c, oTx, frameBit(bb[c / FRAME], (c % FRAME) / CPB));
            end
            if (c == 0) begin
                checks++; if (oFifoCount !== 5'd1) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=1", oFifoCount); end
            end
        end
        @(negedge clk);
        checks++; if (oBusy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_end got=%b exp=0", oBusy); end
        checks++;
        if (rxQ.size() != 2 || rxQ[0] !== bb[0] || rxQ[1] !== bb[1]) begin
            failures++;
            $display("[TB] FAIL b2b_decode size got=%0d exp=2", rxQ.size());
        end
        checks++; if (framingErr != 0) begin failures++; $display("[TB] FAIL b2b_framing got=%0d exp=0", framingErr); end
    endtask

    // mode 0: 10-cycle burst into an empty FIFO; mode 1: valid held across
    // several frame boundaries while full; mode 2: 0..19 streamed only when ready.
    task automatic test_fifo_stream(input int mode);
        int         mCount, lineFreeAt, k, nextVal, peak, ovfSeen, dips;
        bit         mReady, v, push, pop, expOvf, expBusy, done, stimDone, seenFull;
        int         prevObs;
        logic [7:0] d;
        logic [7:0] expQ [$];
        mCount = 0; lineFreeAt = 0; k = 0; nextVal = 0; peak = 0; ovfSeen = 0;
        dips = 0; done = 0; seenFull = 0; prevObs = 0;
        framingErr = 0;
        rxQ.delete();
        @(negedge clk);
        while (!done && k < 3000) begin
            mReady = (mCount < DEPTH);
            case (mode)
                0:       begin v = (k < 10);  d = 8'($urandom_range(0, 255)); end
                1:       begin v = (k < 100); d = 8'($urandom_range(0, 255)); end
                default: begin v = (nextVal < 20) && mReady; d = 8'(nextVal); end
            endcase
            bus.iValid = v;
            bus.iData  = d;
            push = v && mReady;
            pop  = (k >= lineFreeAt) && (mCount > 0);
            if (pop) lineFreeAt = k + FRAME;
            if (push) begin
                expQ.push_back(d);
                nextVal++;
            end
            mCount  = mCount + int'(push) - int'(pop);
            expOvf  = v && !mReady;
            expBusy = !(mCount == 0 && k >= lineFreeAt);
            @(posedge clk);
            @(negedge clk);
            checks++; if (oFifoCount !== 5'(mCount))           begin failures++; $display("[TB] FAIL stream%0d_count k=%0d got=%0d exp=%0d", mode, k, oFifoCount, mCount); end
            checks++; if (bus.oReady !== (mCount < DEPTH))     begin failures++; $display("[TB] FAIL stream%0d_ready k=%0d got=%b exp=%b", mode, k, bus.oReady, mCount < DEPTH); end
            checks++; if (oOverflow !== expOvf)                begin failures++; $display("[TB] FAIL stream%0d_ovf k=%0d got=%b exp=%b", mode, k, oOverflow, expOvf); end
            checks++; if (oBusy !== expBusy)                   begin failures++; $display("[TB] FAIL stream%0d_busy k=%0d got=%b exp=%b", mode, k, oBusy, expBusy); end
            if (int'(oFifoCount) > peak) peak = int'(oFifoCount);
            if (oOverflow === 1'b1) ovfSeen++;
            if (oFifoCount == 5'd8) begin
                if (seenFull && prevObs == 7 && v) dips++;
                seenFull = 1;
            end
            prevObs  = int'(oFifoCount);
            stimDone = (mode == 0) ? (k >= 9) : (mode == 1) ? (k >= 99) : (nextVal >= 20);
            if (stimDone && !expBusy) done = 1;
            k++;
        end
        bus.iValid = 1'b0;
        checks++; if (!done) begin failures++; $display("[TB] FAIL stream%0d_timeout cycles=%0d limit=3000", mode, k); end
        checks++;
        if (rxQ.size() != expQ.size()) begin
            failures++;
            $display("[TB] FAIL stream%0d_rx_count got=%0d exp=%0d", mode, rxQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                checks++;
                if (rxQ[i] !== expQ[i]) begin
                    failures++;
                    $display("[TB] FAIL stream%0d_rx_byte idx=%0d got=%h exp=%h", mode, i, rxQ[i], expQ[i]);
                end
            end
        end
        checks++; if (framingErr != 0) begin failures++; $display("[TB] FAIL stream%0d_framing got=%0d exp=0", mode, framingErr); end
        if (mode == 0) begin
            checks++; if (peak != DEPTH)    begin failures++; $display("[TB] FAIL burst_peak got=%0d exp=%0d", peak, DEPTH); end
            checks++; if (ovfSeen != 1)     begin failures++; $display("[TB] FAIL burst_ovf_pulses got=%0d exp=1", ovfSeen); end
            checks++; if (rxQ.size() != 9)  begin failures++; $display("[TB] FAIL burst_accepted got=%0d exp=9", rxQ.size()); end
        end else if (mode == 1) begin
            checks++; if (dips != 2) begin failures++; $display("[TB] FAIL full_refill got=%0d exp=2", dips); end
        end else begin
            for (int i = 0; i < 20 && i < rxQ.size(); i++) begin
                checks++;
                if (rxQ[i] !== 8'(i)) begin failures++; $display("[TB] FAIL wrap_order idx=%0d got=%h exp=%h", i, rxQ[i], 8'(i)); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int w;
        framingErr = 0;
        rxQ.delete();
        @(negedge clk);
        bus.iData  = 8'hF0;
        bus.iValid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.iData = 8'($urandom_range(0, 255));
            @(posedge clk);
        end
        @(negedge clk);
        bus.iValid = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (oTx !== 1'b0)        begin failures++; $display("[TB] FAIL mid_bit3 got=%b exp=0", oTx); end
        checks++; if (oFifoCount !== 5'd3) begin failures++; $display("[TB] FAIL mid_queued got=%0d exp=3", oFifoCount); end
        #2 rst = 1'b1;
        #1;
        checks++; if (oTx !== 1'b1)        begin failures++; $display("[TB] FAIL async_tx got=%b exp=1", oTx); end
        checks++; if (oFifoCount !== 5'd0) begin failures++; $display("[TB] FAIL async_count got=%0d exp=0", oFifoCount); end
        checks++; if (oBusy !== 1'b0)      begin failures++; $display("[TB] FAIL async_busy got=%b exp=0", oBusy); end
        checks++; if (bus.oReady !== 1'b1) begin failures++; $display("[TB] FAIL async_ready got=%b exp=1", bus.oReady); end
        repeat (2) @(negedge clk);
        rxQ.delete();
        framingErr = 0;
        rst        = 1'b0;
        bus.iData  = 8'h81;
        bus.iValid = 1'b1;
        @(posedge clk);
        #1 bus.iValid = 1'b0;
        @(negedge clk);
        checks++; if (oFifoCount !== 5'd1) begin failures++; $display("[TB] FAIL first_push_count got=%0d exp=1", oFifoCount); end
        w = 0;
        while (oBusy === 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++; if (w >= 200) begin failures++; $display("[TB] FAIL post_reset_timeout cycles=%0d limit=200", w); end
        checks++;
        if (rxQ.size() != 1 || rxQ[0] !== 8'h81) begin
            failures++;
            $display("[TB] FAIL post_reset_decode n=%0d got=%h exp=81", rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 8'hxx);
        end
        checks++; if (framingErr != 0) begin failures++; $display("[TB] FAIL post_reset_framing got=%0d exp=0", framingErr); end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.iData  = 8'd0;
        bus.iValid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_stream(0);
        test_fifo_stream(1);
        test_fifo_stream(2);
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 434, iClock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter: FIFO_DEPTH, 8, byte FIFO depth; power of two, 2..16.
REQ-003 iClock  input  1  single clock; all state changes on its rising edge.
REQ-004 iReset  input  1  reset, asynchronous and active-high.
REQ-005 iData  input  8  byte to transmit; sampled when iValid and oReady are both high.
REQ-006 iValid  input  1  push request for iData.
REQ-007 oReady  output  1  high when FIFO count < FIFO_DEPTH; registered.
REQ-008 oTx  output  1  serial line, 8N1, LSB first, idle high; registered, glitch-free.
REQ-009 oBusy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 oFifoCount  output  5  bytes currently held in the FIFO (0..FIFO_DEPTH).
REQ-011 oOverflow  output  1  one-cycle pulse when iValid is high while oReady is low.

Function
REQ-012 The FIFO shall be circular with wr/rd pointers wrapping modulo FIFO_DEPTH and a separate count register.
REQ-013 A push shall occur at an edge where iValid=1 and oReady=1; the byte is written and count increments at that edge.
REQ-014 With iValid=1 and oReady=0, the byte shall be dropped, FIFO unchanged, and oOverflow high for exactly the next cycle.
REQ-015 Simultaneous push and pop at one edge shall leave count unchanged; both pointers advance.
REQ-016 A pop with FIFO full plus iValid=1 at the same edge shall reject the push, because oReady was low.
REQ-017 FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE: oTx=1; at an edge with count>0, pop the head byte into the shift register, clear the baud counter and bit index, and go to START.
REQ-019 START: oTx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-020 DATA: oTx=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, bits 0..7, then go to STOP after bit 7.
REQ-021 STOP: oTx=1 for CLKS_PER_BIT cycles; on the last cycle, if count>0, pop and go directly to START (no idle gap), else go to IDLE.
REQ-022 Latency: a push into an empty FIFO with FSM in IDLE at edge N shall cause a pop at edge N+1, with oTx=0 from after edge N+1.
REQ-023 Frame length shall be exactly 10*CLKS_PER_BIT cycles; the baud counter counts 0..CLKS_PER_BIT-1 and wraps.
REQ-024 oBusy shall be low only when FSM=IDLE and count=0.
REQ-025 iData and iValid shall have no combinational path to any output.

Reset
REQ-026 While iReset=1, asynchronously force: oTx=1, FSM=IDLE, pointers=0, count=0, oReady=1, oBusy=0, oFifoCount=0, oOverflow=0, baud counter=0.
REQ-027 Reset mid-frame shall abort the frame immediately (oTx=1) and discard all FIFO contents; no partial byte is resumed after release.
REQ-028 The first push shall be accepted at the first rising edge after iReset deasserts.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-029 Push 0x55 when idle -> oTx low from edge N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4 cycles; oBusy falls after 40 cycles.
REQ-030 Push 0xA3 then 0x0F on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; bits LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
REQ-031 Push 10 bytes on consecutive cycles while the first frame starts -> 9 accepted (1 popped + 8 queued), oReady low and 10th byte dropped with a one-cycle oOverflow pulse; oFifoCount peaks at 8.
REQ-032 Full FIFO with iValid held high across the STOP->START pop edge -> count stays 8→7→8 over two edges, no byte lost or duplicated, received order preserved.
REQ-033 Assert iReset during DATA bit 3 of 0xF0 with 3 bytes queued -> oTx=1 immediately, oFifoCount=0, oBusy=0; after release, push 0x81 -> a clean frame of 0x81 only.
REQ-034 Pointer wrap: stream 20 bytes 0x00..0x13 respecting oReady -> the UART monitor decodes all 20 in order.
